// File: rtl/add_ctrl_pkg.sv
// Shared definitions for the multiword adder controller:
// FSM state encoding and index counter width helper.
package add_ctrl_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] RUN_ENC  = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC,
    DONE = DONE_ENC
  } state_t;

  // Index counter width; a single-word operand still needs one bit.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_adder_controller_adder.sv
// Narrow ripple word adder shared by the multiword controller.
// Pure combinational: {Carry_out, Sum} = Data_1 + Data_2 + Carry_in.
module Multiple_bits_Adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] Data_1,
  input  logic [WIDTH-1:0] Data_2,
  input  logic             Carry_in,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out
);

  assign {Carry_out, Sum} = {1'b0, Data_1}
                          + {1'b0, Data_2}
                          + {{WIDTH{1'b0}}, Carry_in};

endmodule

// File: rtl/multiword_adder_controller.sv
// Wide adder sequencer: iterates one narrow adder over WORDS words,
// LSW first, chaining the carry through a register.
module multiword_adder_controller
  import add_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   In_valid,
  output logic                   In_ready,
  input  logic [WIDTH*WORDS-1:0] Operand_A,
  input  logic [WIDTH*WORDS-1:0] Operand_B,
  input  logic                   Carry_in,
  output logic                   Out_valid,
  input  logic                   Out_ready,
  output logic [WIDTH*WORDS-1:0] Result,
  output logic                   Carry_out
);

  localparam int W  = WIDTH * WORDS;
  localparam int IW = idx_w(WORDS);

  state_t          state;
  state_t          state_nx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic [IW-1:0]   idx;
  logic            carry_q;
  logic            cout_q;

  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH-1:0] sum_w;
  logic             c_w;
  logic             last;
  logic             accept;

  assign a_w    = a_q[idx*WIDTH +: WIDTH];
  assign b_w    = b_q[idx*WIDTH +: WIDTH];
  assign last   = (idx == IW'(WORDS - 1));
  assign accept = In_valid && (state == IDLE);

  Multiple_bits_Adder #(
    .WIDTH(WIDTH)
  ) u_add (
    .Data_1   (a_w),
    .Data_2   (b_w),
    .Carry_in (carry_q),
    .Sum      (sum_w),
    .Carry_out(c_w)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept -> iterate words -> hold until consumed
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (In_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (Out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, index, carry chain and result words
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= Operand_A;
      b_q     <= Operand_B;
      idx     <= '0;
      carry_q <= Carry_in;
    end else if (state == RUN) begin
      res_q[idx*WIDTH +: WIDTH] <= sum_w;
      carry_q <= c_w;
      if (last) cout_q <= c_w;
      else      idx    <= idx + 1'b1;
    end
  end

  assign In_ready  = (state == IDLE);
  assign Out_valid = (state == DONE);
  assign Result    = res_q;
  assign Carry_out = cout_q;

endmodule

// File: tb/tb_multiword_adder_controller.sv
// Scoreboard bench for multiword_adder_controller (WIDTH=4, WORDS=4).
// Expected sums come from plain 17-bit arithmetic on the operands.
module tb_multiword_adder_controller;

  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int W     = WIDTH * WORDS;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic [W-1:0] Operand_A = '0;
  logic [W-1:0] Operand_B = '0;
  logic         Carry_in = 1'b0;
  logic         Out_valid;
  logic         Out_ready = 1'b1;
  logic [W-1:0] Result;
  logic         Carry_out;

  multiword_adder_controller #(
    .WIDTH(WIDTH),
    .WORDS(WORDS)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .Operand_A(Operand_A),
    .Operand_B(Operand_B),
    .Carry_in (Carry_in),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Result   (Result),
    .Carry_out(Carry_out)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int hs_cyc  = 0;
  logic [W:0] expq[$];
  logic       prev_v = 1'b0;
  logic [W:0] held;
  logic       rand_bp = 1'b0;

  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c);
    int n;
    n = 0;
    @(negedge Clk);
    In_valid  = 1'b1;
    Operand_A = a;
    Operand_B = b;
    Carry_in  = c;
    while (!In_ready && n < 60) begin
      @(negedge Clk);
      n++;
    end
    if (!In_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no In_ready expected In_ready");
      In_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    expq.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    @(posedge Clk);
    #1;
    In_valid  = 1'b0;
    Operand_A = W'($urandom);
    Operand_B = W'($urandom);
    Carry_in  = 1'($urandom);
  endtask

  // Monitor: latency, stability under backpressure, scoreboard pop
  always @(negedge Clk) begin
    if (Rst) begin
      prev_v = 1'b0;
    end else if (Out_valid) begin
      chk("in_ready_low_in_done", {63'd0, In_ready}, 64'd0);
      if (!prev_v)
        chk("latency", 64'(cyc - acc_cyc), 64'(WORDS + 1));
      else
        chk("hold_stable", 64'({Carry_out, Result}), 64'(held));
      held   = {Carry_out, Result};
      prev_v = 1'b1;
      if (Out_ready) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none",
                   {Carry_out, Result});
        end else begin
          chk("result", 64'({Carry_out, Result}), 64'(expq.pop_front()));
        end
        hs_cyc = cyc;
        prev_v = 1'b0;
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  // Random consumer backpressure
  always @(posedge Clk) begin
    if (rand_bp) begin
      #1;
      Out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    int n;
    logic [W:0] bp_exp;
    // Reset held two cycles with random inputs
    In_valid  = 1'($urandom);
    Operand_A = W'($urandom);
    Operand_B = W'($urandom);
    Carry_in  = 1'($urandom);
    Out_ready = 1'($urandom);
    repeat (2) @(posedge Clk);
    #1;
    Rst       = 1'b0;
    In_valid  = 1'b0;
    Out_ready = 1'b1;
    @(negedge Clk);
    chk("rst_in_ready", {63'd0, In_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, Out_valid}, 64'd0);
    chk("rst_result", 64'(Result), 64'h0);
    chk("rst_carry_out", {63'd0, Carry_out}, 64'd0);

    // Basic add and full ripple cases
    send(16'h1234, 16'h4321, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1);

    // Backpressure: 3 DONE cycles without Out_ready, next op held
    send(16'h8000, 16'h8000, 1'b0);
    #1 Out_ready = 1'b0;
    fork
      send(16'h0003, 16'h0004, 1'b1);
      begin
        n = 0;
        do begin
          @(negedge Clk);
          n++;
        end while (!Out_valid && n < 20);
        if (!Out_valid) begin
          n_chk++;
          n_fail++;
          $display("FAIL bp_timeout: got no Out_valid expected Out_valid");
        end
        bp_exp = {Carry_out, Result};
        chk("bp_value", 64'(bp_exp), 64'h10000);
        repeat (3) @(posedge Clk);
        #1 Out_ready = 1'b1;
      end
    join
    chk("bp_accept_cycle", 64'(acc_cyc), 64'(hs_cyc + 1));

    // Abort during the third RUN cycle
    send(16'h0F0F, 16'h00F1, 1'b0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    void'(expq.pop_back());
    @(negedge Clk);
    chk("abort_in_ready", {63'd0, In_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, Out_valid}, 64'd0);
    chk("abort_result", 64'(Result), 64'h0);
    chk("abort_carry_out", {63'd0, Carry_out}, 64'd0);
    send(16'h0001, 16'h0001, 1'b0);

    // Carry isolation, back to back
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h0001, 16'h0001, 1'b0);

    // Random operations with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    @(posedge Clk);
    rand_bp = 1'b0;
    #1 Out_ready = 1'b1;

    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
